// File: rtl/decode_control_stage.sv
// Registered RV32I ID/EX control decoder with a 2-entry skid buffer,
// flush, optional MUL decode and a saturating illegal-instruction counter.
module decode_control_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instr,
  input  logic [XLEN-1:0]  PCIn,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  PCOut,
  output logic [XLEN-1:0]  Imm,
  output logic [4:0]       Rs1,
  output logic [4:0]       Rs2,
  output logic [4:0]       Rd,
  output logic             RegWrite,
  output logic             Dmem1ALUOUT,
  output logic             DmemREB,
  output logic             DmemWEB,
  output logic [3:0]       ALUControl,
  output logic             ALUSourceA,
  output logic [2:0]       ALUSourceB,
  output logic             LoadStoremuxsel,
  output logic             mux2sel,
  output logic             Illegal,
  output logic [CNT_W-1:0] IllegalCount
);

  localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SLTU = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                         ALU_SUB  = 4'b0110, ALU_SLT = 4'b0111, ALU_SRL = 4'b1000,
                         ALU_SRA  = 4'b1001, ALU_MUL = 4'b1010;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            d1alu;
    logic            reb;
    logic            web;
    logic [3:0]      aluctl;
    logic [2:0]      srcb;
    logic            lsmux;
    logic            mux2;
    logic            illegal;
  } ent_t;

  function automatic ent_t safe_ent();
    ent_t e;
    e        = '0;
    e.reb    = 1'b1;
    e.web    = 1'b1;
    e.aluctl = ALU_ADD;
    return e;
  endfunction

  function automatic ent_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    ent_t       e;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    f7 = ins[31:25];
    f3 = ins[14:12];
    ok = 1'b0;
    e  = safe_ent();
    case (ins[6:0])
      7'b0110011: begin
        e.regwrite = 1'b1;
        if (f7 == 7'b0000000) begin
          ok = 1'b1;
          case (f3)
            3'b000:  e.aluctl = ALU_ADD;
            3'b001:  e.aluctl = ALU_SLL;
            3'b010:  e.aluctl = ALU_SLT;
            3'b011:  e.aluctl = ALU_SLTU;
            3'b100:  e.aluctl = ALU_XOR;
            3'b101:  e.aluctl = ALU_SRL;
            3'b110:  e.aluctl = ALU_OR;
            default: e.aluctl = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          ok = 1'b1; e.aluctl = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          ok = 1'b1; e.aluctl = ALU_SRA;
        end else if (ENABLE_M != 0 && f7 == 7'b0000001 && f3 == 3'b000) begin
          ok = 1'b1; e.aluctl = ALU_MUL;
        end
      end
      7'b0010011: begin
        e.regwrite = 1'b1;
        e.srcb     = 3'b010;
        e.imm      = {{(XLEN-12){ins[31]}}, ins[31:20]};
        ok         = 1'b1;
        case (f3)
          3'b000:  e.aluctl = ALU_ADD;
          3'b010:  e.aluctl = ALU_SLT;
          3'b011:  e.aluctl = ALU_SLTU;
          3'b100:  e.aluctl = ALU_XOR;
          3'b110:  e.aluctl = ALU_OR;
          3'b111:  e.aluctl = ALU_AND;
          default: begin
            // Shift-immediates: only the shamt reaches the ALU, zero-extended
            e.srcb = 3'b100;
            e.imm  = {{(XLEN-5){1'b0}}, ins[24:20]};
            if (f3 == 3'b001 && f7 == 7'b0000000)      e.aluctl = ALU_SLL;
            else if (f3 == 3'b101 && f7 == 7'b0000000) e.aluctl = ALU_SRL;
            else if (f3 == 3'b101 && f7 == 7'b0100000) e.aluctl = ALU_SRA;
            else                                       ok = 1'b0;
          end
        endcase
      end
      7'b0000011: if (f3 == 3'b010) begin
        ok = 1'b1; e.srcb = 3'b011; e.d1alu = 1'b1; e.reb = 1'b0;
        e.mux2 = 1'b1; e.regwrite = 1'b1;
        e.imm  = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      7'b0100011: if (f3 == 3'b010) begin
        ok = 1'b1; e.srcb = 3'b011; e.d1alu = 1'b1; e.web = 1'b0; e.lsmux = 1'b1;
        e.imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) e = safe_ent();
    e.illegal = !ok;
    e.pc      = pc;
    e.rs1     = ins[19:15];
    e.rs2     = ins[24:20];
    e.rd      = ins[11:7];
    if (e.rd == 5'd0) e.regwrite = 1'b0;
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  ent_t             r_head, r_skid, w_dec;
  logic             r_ov, r_sv, w_push, w_pop;
  logic [CNT_W-1:0] r_cnt;

  assign w_dec   = decode(Instr, PCIn);
  assign InReady = !r_sv && !RST;
  assign w_push  = InValid && InReady;
  assign w_pop   = r_ov && OutReady;

  // Stage p0 -> p1: head register; the skid entry only fills while head is stalled
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ov   <= 1'b0;
      r_sv   <= 1'b0;
      r_cnt  <= '0;
      r_head <= safe_ent();
      r_head.aluctl <= 4'b0000;
    end else if (Flush) begin
      r_ov <= 1'b0;
      r_sv <= 1'b0;
    end else begin
      if (w_push && w_dec.illegal) r_cnt <= sat_inc(r_cnt);
      if (!r_ov || w_pop) begin
        if (r_sv) begin
          r_head <= r_skid;
          r_ov   <= 1'b1;
          r_sv   <= 1'b0;
        end else if (w_push) begin
          r_head <= w_dec;
          r_ov   <= 1'b1;
        end else begin
          r_ov   <= 1'b0;
        end
      end else if (w_push) begin
        r_sv <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && !Flush && r_ov && !w_pop && w_push) r_skid <= w_dec;
  end

  assign OutValid        = r_ov;
  assign PCOut           = r_head.pc;
  assign Imm             = r_head.imm;
  assign Rs1             = r_head.rs1;
  assign Rs2             = r_head.rs2;
  assign Rd              = r_head.rd;
  assign RegWrite        = r_ov && r_head.regwrite;
  assign Dmem1ALUOUT     = r_head.d1alu;
  assign DmemREB         = !r_ov || r_head.reb;
  assign DmemWEB         = !r_ov || r_head.web;
  assign ALUControl      = r_head.aluctl;
  assign ALUSourceA      = 1'b0;
  assign ALUSourceB      = r_head.srcb;
  assign LoadStoremuxsel = r_head.lsmux;
  assign mux2sel         = r_head.mux2;
  assign Illegal         = r_head.illegal;
  assign IllegalCount    = r_cnt;

endmodule

// File: doc/decode_control_stage.md
Name: decode_control_stage

Overview:
- Next-generation registered ID/EX control decoder. Accepts a full 32-bit RV32I instruction plus PC through a valid/ready handshake.
- Decodes the ALU, datapath-mux and data-memory control set, the register indices, a sign-extended immediate and an illegal-instruction flag.
- Holds results in a 2-entry skid buffer so EX back-pressure never drops an instruction.
- Adds flush, optional M-extension MUL decode and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, width of PC and immediate datapath (>=32; immediates sign-extended to XLEN).
- ENABLE_M, 0, 1 = decode MUL (funct7 0000001, funct3 000); 0 = that encoding is illegal.
- CNT_W, 8, width of IllegalCount.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- InValid  in  1  instruction presented
- InReady  out  1  stage can accept
- Instr  in  32  instruction word
- PCIn  in  XLEN  instruction PC
- Flush  in  1  discard all held and incoming entries
- OutValid  out  1  head entry valid
- OutReady  in  1  EX accepts head entry
- PCOut  out  XLEN  head PC
- Imm  out  XLEN  sign-extended immediate: I-form for OP-IMM/LW, S-form for SW, zero-extended shamt for shifts, 0 for R-type
- Rs1, Rs2, Rd  out  5 each  register indices from Instr[19:15], [24:20], [11:7]
- RegWrite  out  1  writeback enable
- Dmem1ALUOUT  out  1  ALU result is a memory address
- DmemREB  out  1  data-memory read, active low
- DmemWEB  out  1  data-memory write, active low
- ALUControl  out  4  ALU operation
- ALUSourceA  out  1  0 = rs1, 1 = PC (always 0 in this generation)
- ALUSourceB  out  3  000 rs2, 010 I-imm, 011 load/store offset, 100 shamt
- LoadStoremuxsel  out  1  1 = rs2 routed to memory write data
- mux2sel  out  1  1 = writeback from memory
- Illegal  out  1  head entry is an illegal encoding
- IllegalCount  out  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset (RST=1 at an edge, any state):
  - entry count = 0, OutValid = 0, IllegalCount = 0.
  - Head fields reset to safe values: RegWrite=0, DmemREB=1, DmemWEB=1, Illegal=0; all other outputs 0.
- InReady = (count < 2) and not RST. It is combinational from state only, never from InValid or OutReady.
- Push on InValid & InReady; pop on OutValid & OutReady.
- Ordering and latency:
  - FIFO order.
  - Accepted into an empty stage: OutValid=1 with decoded fields on the next cycle (1-cycle latency).
  - Sustained throughput is 1 instruction/cycle with OutReady held high.
  - Push and pop in the same cycle at count=1: count stays 1 and the new entry becomes head.
- Output fields are registered and hold stable while OutValid=1 and OutReady=0.
- When OutValid=0, fields hold the last popped values, except that DmemREB/DmemWEB/RegWrite are forced to their safe values.
- Flush priority: RST > Flush > push/pop.
  - On Flush: count=0 next cycle and any same-cycle incoming instruction is discarded.
  - A discarded instruction does not increment IllegalCount.
- ALUControl encoding: AND 0000, OR 0001, ADD 0010, SLTU 0011, XOR 0100, SLL 0101, SUB 0110, SLT 0111, SRL 1000, SRA 1001, MUL 1010.
- Decode, opcode 0110011 (R-type):
  - funct7 0000000 + funct3 000/001/010/011/100/101/110/111 → ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 0100000 + funct3 000 → SUB; + funct3 101 → SRA.
  - funct7 0000001 + funct3 000 → MUL, only when ENABLE_M=1.
  - ALUSourceB=000, RegWrite=1.
- Decode, opcode 0010011 (OP-IMM):
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI use ALUSourceB=010.
  - SLLI (funct7 0000000), SRLI (0000000), SRAI (0100000) use ALUSourceB=100.
  - RegWrite=1.
- Decode, opcode 0000011 + funct3 010 (LW): ADD, ALUSourceB=011, Dmem1ALUOUT=1, DmemREB=0, mux2sel=1, RegWrite=1.
- Decode, opcode 0100011 + funct3 010 (SW): ADD, ALUSourceB=011, Dmem1ALUOUT=1, DmemWEB=0, LoadStoremuxsel=1, RegWrite=0.
- RegWrite is forced to 0 when Rd=0.
- Any other encoding:
  - Illegal=1; safe control values (DmemREB=DmemWEB=1, RegWrite=0, ALUControl=0010); entry still flows normally.
  - IllegalCount increments on push of an illegal entry and saturates at all-ones.

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3), OutReady=1 → next cycle OutValid=1, ALUControl=0010, ALUSourceB=000, RegWrite=1, Rd=3, DmemREB=DmemWEB=1.
- Back-to-back LW x5,8(x1) (0x0080A283), SW x5,-4(x2) (0xFE512E23) → LW: DmemREB=0, mux2sel=1, Imm=8. SW: DmemWEB=0, LoadStoremuxsel=1, Imm=0xFFFFFFFC, RegWrite=0.
- OutReady=0 with 3 pushes attempted → InReady drops after 2 accepted. Releasing OutReady drains both in order with no loss; the third is accepted once count<2.
- Flush with count=2 and InValid=1 → next cycle OutValid=0 and count=0; the incoming instruction never appears.
- ENABLE_M=0: push MUL (0x022081B3) 300 times with CNT_W=8 → Illegal=1 each time, IllegalCount saturates at 255. With ENABLE_M=1, the same word decodes ALUControl=1010.
- Assert RST mid-stream with count=2 → next cycle OutValid=0, IllegalCount=0, DmemREB=DmemWEB=1, InReady=1 after RST deasserts.
